attention_core_param: RTL and testbench
=======================================

# attention_core_param

Parametrised single-head attention core computing O = (Q·Kᵀ)·V over N×N matrices of unsigned DW-bit elements, with an optional score-only mode returning S = Q·Kᵀ. It is the generalised successor of the fixed 8×8, 4-bit attention engine. Q, K and V are streamed in together, one element of each per handshake, in row-major order. Results are streamed out row-major through a valid/ready port that supports backpressure. It sits between the matrix stream sources and the downstream result sink.

## Interface
- N, default 8: matrix dimension; N ≥ 2, power of two.
- DW, default 4: element width, unsigned.
- LN, derived, clog2(N).
- SW, derived, 2·DW+LN: width of a score element S.
- OW, derived, 3·DW+2·LN: output width (18 at defaults).
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_q/in_k/in_v carry a valid element.
- in_ready  output  1  core accepts input (IDLE or LOAD).
- in_q, in_k, in_v  input  DW each  element (i,j) of Q, K, V; stream index = i·N+j.
- mode  input  1  0 = full attention O; 1 = scores S only. Sampled on the first accepted element of a frame.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts out_data.
- out_data  output  OW  result element, row-major; S results are zero-extended to OW.
- out_last  output  1  high with the final element of the frame (index N²−1).
- busy  output  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → LOAD on the first accepted element.
  - LOAD → CALC_S on acceptance of element N²−1.
  - CALC_S → CALC_O when mode = 0, or → OUT when mode = 1, after N² cycles.
  - CALC_O → OUT after N² cycles.
  - OUT → IDLE on the handshake of the last output.
- Input acceptance: an element is accepted when in_valid && in_ready. in_valid while in_ready = 0 is ignored. Gaps in in_valid are allowed with no time limit.
- Storage: Q, K and V register arrays of N²·DW bits each; S array of N²·SW bits.
- CALC_S: one S element per cycle, S[i][j] = Σk Q[i][k]·K[j][k], using N parallel multipliers and an adder tree. Elements are computed in row-major order.
- CALC_O: one O element per cycle, O[i][j] = Σk S[i][k]·V[k][j], computed row-major.
- Arithmetic is full-precision unsigned and cannot overflow at SW/OW widths; no truncation or saturation.
- OUT: emits N² elements in row-major order. out_data, out_last and out_valid are registered. They hold stable while out_valid && !out_ready; the element advances only on a handshake.
- A reset assertion in any state discards the partial frame, clears all counters and returns to IDLE.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0. The core is in IDLE.
- in_ready drops to 0 in the cycle after the edge that accepts element N²−1.
- Let E0 be the edge accepting element N²−1. out_valid is high in the cycle after edge E0 + 2·N² for mode 0, or E0 + N² for mode 1 (128 or 64 cycles at the defaults).
- With out_ready held at 1, the frame drains in N² consecutive cycles.
- The cycle after the last output handshake: out_valid = 0, out_last = 0, busy = 0, in_ready = 1. A new frame may be accepted in that cycle.
- mode changes after the first element of a frame have no effect until the next frame.
- reset deasserting mid-cycle: the first accepted element is no earlier than the first rising edge after release.

## Test plan
- Defaults, Q = K = V = all 1, in_valid held high, out_ready = 1 -> 64 outputs of 64. out_last on the 64th. First out_valid exactly 128 cycles after the last input accept.
- Q = K = V = all 15 -> every output is 216000 (fits 18 bits). Repeat with random in_valid gaps -> identical results and the same latency measured from the last accept.
- Q = K = identity, V[i][j] = (i+j) mod 16 -> outputs equal V in row-major order.
- mode = 1, Q = K = all 2 -> 64 outputs of 32. First out_valid 64 cycles after the last accept. out_last on the 64th.
- out_ready toggling 1,0,0,1,… during OUT -> each value held while stalled. Exactly 64 handshakes, in order, no duplicates or drops.
- Reset asserted after 30 accepted elements -> all outputs return to reset values and in_ready = 1. A following full frame (test 1 data) yields 64 outputs of 64.

Source files
------------

// File: rtl/attention_core_param_if.sv
// Stream interface for attention_core_param.
// Input side : in_valid/in_ready handshake carrying one Q, K and V element plus mode.
// Output side: out_valid/out_ready handshake carrying a result element and out_last.
// master = stream source/sink side, slave = core side.
interface attention_core_param_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 4
);
    localparam int unsigned LN = $clog2(N);
    localparam int unsigned OW = 3 * DW + 2 * LN;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_q;
    logic [DW-1:0] in_k;
    logic [DW-1:0] in_v;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;

    modport master (
        output in_valid, in_q, in_k, in_v, mode, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_q, in_k, in_v, mode, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/attention_core_param.sv
// Single-head attention core: O = (Q*K^T)*V over NxN unsigned DW-bit matrices,
// or S = Q*K^T only when mode = 1 (sampled with the first element of a frame).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of attention_core_param_if (input stream, result stream)
//   busy  : high in every state except IDLE
// Q/K/V stream in row-major, one element of each per handshake. S and O are
// each computed one element per cycle (N multipliers + adder), then results
// stream out row-major with full backpressure support.
module attention_core_param #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    attention_core_param_if.slave bus,
    output logic                  busy
);
    localparam int unsigned LN = $clog2(N);
    localparam int unsigned IW = 2 * LN;
    localparam int unsigned NN = N * N;
    localparam int unsigned SW = 2 * DW + LN;
    localparam int unsigned OW = 3 * DW + 2 * LN;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC_S,
        CALC_O,
        OUT
    } state_t;

    state_t        state;
    logic [IW-1:0] cnt;
    logic          mode_r;

    logic [DW-1:0] q_mem [NN];
    logic [DW-1:0] k_mem [NN];
    logic [DW-1:0] v_mem [NN];
    logic [SW-1:0] s_mem [NN];
    // Result buffer: holds S (zero-extended) after CALC_S, overwritten by O in CALC_O.
    logic [OW-1:0] r_mem [NN];

    logic          acc_c;
    logic [LN-1:0] row_c;
    logic [LN-1:0] col_c;
    logic [IW-1:0] nxt_c;
    logic [SW-1:0] s_dot_c;
    logic [OW-1:0] o_dot_c;

    assign acc_c = bus.in_valid && bus.in_ready;
    assign row_c = cnt[IW-1:LN];
    assign col_c = cnt[LN-1:0];
    assign nxt_c = cnt + IW'(1);

    // S[i][j] = sum_k Q[i][k] * K[j][k]
    always_comb begin
        s_dot_c = '0;
        for (int k = 0; k < int'(N); k++) begin
            s_dot_c = s_dot_c + SW'(q_mem[{row_c, LN'(k)}]) * SW'(k_mem[{col_c, LN'(k)}]);
        end
    end

    // O[i][j] = sum_k S[i][k] * V[k][j]
    always_comb begin
        o_dot_c = '0;
        for (int k = 0; k < int'(N); k++) begin
            o_dot_c = o_dot_c + OW'(s_mem[{row_c, LN'(k)}]) * OW'(v_mem[{LN'(k), col_c}]);
        end
    end

    // Matrix storage; cnt doubles as the load index (it is zero in IDLE).
    always_ff @(posedge clk) begin
        if (acc_c) begin
            q_mem[cnt] <= bus.in_q;
            k_mem[cnt] <= bus.in_k;
            v_mem[cnt] <= bus.in_v;
        end
        if (state == CALC_S) begin
            s_mem[cnt] <= s_dot_c;
            r_mem[cnt] <= OW'(s_dot_c);
        end
        if (state == CALC_O) begin
            r_mem[cnt] <= o_dot_c;
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            mode_r        <= 1'b0;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_c) begin
                        state  <= LOAD;
                        cnt    <= nxt_c;
                        mode_r <= bus.mode;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (acc_c) begin
                        if (cnt == IW'(NN - 1)) begin
                            state        <= CALC_S;
                            cnt          <= '0;
                            bus.in_ready <= 1'b0;
                        end else begin
                            cnt <= nxt_c;
                        end
                    end
                end
                CALC_S: begin
                    if (cnt == IW'(NN - 1)) begin
                        cnt <= '0;
                        if (mode_r) begin
                            // r_mem[0] was written on the first CALC_S cycle.
                            state         <= OUT;
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= r_mem[0];
                            bus.out_last  <= 1'b0;
                        end else begin
                            state <= CALC_O;
                        end
                    end else begin
                        cnt <= nxt_c;
                    end
                end
                CALC_O: begin
                    if (cnt == IW'(NN - 1)) begin
                        state         <= OUT;
                        cnt           <= '0;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= r_mem[0];
                        bus.out_last  <= 1'b0;
                    end else begin
                        cnt <= nxt_c;
                    end
                end
                OUT: begin
                    // out_valid is always high here, so out_ready alone is the handshake.
                    if (bus.out_ready) begin
                        if (bus.out_last) begin
                            state         <= IDLE;
                            cnt           <= '0;
                            busy          <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            bus.out_valid <= 1'b0;
                            bus.out_data  <= '0;
                            bus.out_last  <= 1'b0;
                        end else begin
                            cnt          <= nxt_c;
                            bus.out_data <= r_mem[nxt_c];
                            bus.out_last <= (cnt == IW'(NN - 2));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_attention_core_param.sv
// Directed bench for attention_core_param at default parameters (N=8, DW=4).
module tb_attention_core_param;
    localparam int N  = 8;
    localparam int NN = N * N;

    logic clk;
    logic reset;
    logic busy;
    int   cyc;
    int   e0;
    int   n_checks;
    int   n_pass;

    int q_a   [NN];
    int k_a   [NN];
    int v_a   [NN];
    int exp_a [NN];

    attention_core_param_if #(.N(8), .DW(4)) ifc ();

    attention_core_param #(.N(8), .DW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Stream 'count' elements; mode is driven only correct on the first element
    // and inverted afterwards, which must not affect the frame.
    task automatic send_frame(input logic m, input bit gaps, input int count);
        int idx;
        int t;
        idx = 0;
        t   = 0;
        while (idx < count && t < 4000) begin
            @(negedge clk);
            t++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                ifc.in_valid = 1'b0;
            end else begin
                ifc.in_valid = 1'b1;
                ifc.in_q     = 4'(q_a[idx]);
                ifc.in_k     = 4'(k_a[idx]);
                ifc.in_v     = 4'(v_a[idx]);
                ifc.mode     = (idx == 0) ? m : ~m;
                if (ifc.in_ready) begin
                    idx++;
                    if (idx == NN) e0 = cyc + 1;
                end
            end
        end
        if (idx < count) check("send_timeout", 64'(idx), 64'(count));
        @(negedge clk);
        ifc.in_valid = 1'b0;
        if (count == NN) check("in_ready_drop", 64'(ifc.in_ready), 64'd0);
    endtask

    // Collect one frame of results against exp_a; optional 1,0,0,1 stall pattern.
    task automatic run_out(input bit stall, input int lat_exp);
        int hs;
        int ph;
        int t;
        int first_hs;
        int last_hs;
        bit seen;
        bit held;
        logic [63:0] held_data;
        hs   = 0;
        ph   = 0;
        t    = 0;
        seen = 0;
        held = 0;
        held_data = '0;
        first_hs = 0;
        last_hs  = 0;
        while (hs < NN && t < 3000) begin
            @(negedge clk);
            t++;
            ifc.out_ready = stall ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            if (held) begin
                check("hold_valid", 64'(ifc.out_valid), 64'd1);
                check("hold_data", 64'(ifc.out_data), held_data);
            end
            if (ifc.out_valid) begin
                if (!seen) begin
                    check("latency", 64'(cyc - e0), 64'(lat_exp));
                    seen = 1;
                end
                ph++;
                if (ifc.out_ready) begin
                    check("data", 64'(ifc.out_data), 64'(exp_a[hs]));
                    check("last", 64'(ifc.out_last), 64'(hs == NN - 1));
                    if (hs == 0) first_hs = cyc;
                    last_hs = cyc;
                    hs++;
                    held = 0;
                end else begin
                    held = 1;
                    held_data = 64'(ifc.out_data);
                end
            end
        end
        if (hs < NN) check("out_timeout", 64'(hs), 64'(NN));
        if (!stall) check("drain_cycles", 64'(last_hs - first_hs), 64'(NN - 1));
        @(negedge clk);
        check("end_out_valid", 64'(ifc.out_valid), 64'd0);
        check("end_out_last", 64'(ifc.out_last), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        check("end_in_ready", 64'(ifc.in_ready), 64'd1);
    endtask

    task automatic fill_const(input int qv, input int kv, input int vv, input int ev);
        for (int i = 0; i < NN; i++) begin
            q_a[i] = qv;
            k_a[i] = kv;
            v_a[i] = vv;
            exp_a[i] = ev;
        end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                q_a[i*N+j]   = (i == j) ? 1 : 0;
                k_a[i*N+j]   = (i == j) ? 1 : 0;
                v_a[i*N+j]   = (i + j) % 16;
                exp_a[i*N+j] = (i + j) % 16;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  64'(ifc.in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(ifc.out_valid), 64'd0);
        check({tag, "_out_data"},  64'(ifc.out_data),  64'd0);
        check({tag, "_out_last"},  64'(ifc.out_last),  64'd0);
        check({tag, "_busy"},      64'(busy),          64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        e0       = 0;
        reset         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_q      = '0;
        ifc.in_k      = '0;
        ifc.in_v      = '0;
        ifc.mode      = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;

        // All ones: S = 8, O = 64
        fill_const(1, 1, 1, 64);
        send_frame(1'b0, 0, NN);
        run_out(0, 2 * NN);

        // All fifteens: S = 1800, O = 216000
        fill_const(15, 15, 15, 216000);
        send_frame(1'b0, 0, NN);
        run_out(0, 2 * NN);

        // Same data with random input gaps
        send_frame(1'b0, 1, NN);
        run_out(0, 2 * NN);

        // Identity Q/K: O equals V
        fill_identity();
        send_frame(1'b0, 0, NN);
        run_out(0, 2 * NN);

        // Score-only mode, Q = K = 2: S = 32
        fill_const(2, 2, 0, 32);
        send_frame(1'b1, 0, NN);
        run_out(0, NN);

        // Backpressure with distinct values
        fill_identity();
        send_frame(1'b0, 0, NN);
        run_out(1, 2 * NN);

        // Reset mid-load, then a clean frame
        fill_const(1, 1, 1, 64);
        send_frame(1'b0, 0, 30);
        ifc.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b1;
        send_frame(1'b0, 0, NN);
        run_out(0, 2 * NN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
